// File: rtl/srv1_pkg.sv
// Shared types and constants for the memory stage: bus op codes, funct3 widths,
// FSM states and the writeback-facing instruction fields.
package srv1_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    IDLE     = 1'b0,
    BUS_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [2:0]  ctr_word;
    logic [2:0]  fn3;
    logic [4:0]  rd_addr;
    logic [31:0] alu;
    logic [29:0] inc_pc;
    logic [19:0] u_type_imm;
  } wb_fields_t;

endpackage

// File: rtl/memory_stage_store_align.sv
// Store formatting and access legality: lane-replicated write data, byte strobes,
// funct3 legality for loads/stores and natural-alignment check.
module store_align
  import srv1_pkg::*;
(
  input  logic [2:0]  fn3,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        load_legal,
  output logic        store_legal,
  output logic        aligned
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    wdata   = data;
    wstrb   = 4'b1111;
    aligned = 1'b1;
    case (fn3[1:0])
      2'b00: begin
        wdata = {4{data[7:0]}};
        wstrb = 4'b0001 << addr;
      end
      2'b01: begin
        wdata   = {2{data[15:0]}};
        wstrb   = addr[1] ? 4'b1100 : 4'b0011;
        aligned = ~addr[0];
      end
      2'b10: aligned = (addr == 2'b00);
      default: ;
    endcase
  end

  assign load_legal  = fn3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign store_legal = fn3 inside {F3_B, F3_H, F3_W};

endmodule

// File: rtl/memory_stage.sv
// Execute-to-writeback pipeline register with a single outstanding data-bus
// access (req/ack), fault reporting and an optional bus timeout.
module memory_stage
  import srv1_pkg::*;
#(
  parameter int BUS_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  mem_op_in,
  input  logic [2:0]  ctr_word_in,
  input  logic [2:0]  fn3_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_data_in,
  input  logic [29:0] inc_pc_in,
  input  logic [19:0] u_type_imm_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic [2:0]  ctr_word_out,
  output logic [2:0]  fn3_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] alu_out,
  output logic [29:0] inc_pc_out,
  output logic [19:0] u_type_imm_out,
  output logic [31:0] memory_data_out,
  output logic        mem_fault
);

  localparam int CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;

  mem_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  wb_fields_t       wb_q, shadow_q, fields_in;
  logic             shadow_load;

  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        load_legal, store_legal, aligned;

  logic accept, is_load, is_store, is_mem, access_ok;
  logic start_access, reject_access, timeout_hit;

  store_align u_store_align (
    .fn3        (fn3_in),
    .addr       (alu_in[1:0]),
    .data       (store_data_in),
    .wdata      (st_wdata),
    .wstrb      (st_wstrb),
    .load_legal (load_legal),
    .store_legal(store_legal),
    .aligned    (aligned)
  );

  assign fields_in = '{ctr_word: ctr_word_in, fn3: fn3_in, rd_addr: rd_addr_in,
                       alu: alu_in, inc_pc: inc_pc_in, u_type_imm: u_type_imm_in};

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign is_load   = (mem_op_t'(mem_op_in) == MEM_LOAD);
  assign is_store  = (mem_op_t'(mem_op_in) == MEM_STORE);
  assign is_mem    = is_load || is_store;
  assign access_ok = aligned && (is_load ? load_legal : store_legal);

  // Zero disables the timeout; the counter then simply wraps.
  assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt == CNT_W'(BUS_TIMEOUT - 1));

  always_comb begin
    next_state    = state;
    start_access  = 1'b0;
    reject_access = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_mem) begin
          start_access  = access_ok;
          reject_access = ~access_ok;
          if (access_ok) next_state = BUS_WAIT;
        end
      end
      BUS_WAIT: begin
        if (bus_ack || timeout_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q            <= '0;
      shadow_q        <= '0;
      shadow_load     <= 1'b0;
      cnt             <= '0;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_wstrb       <= '0;
      bus_wdata       <= '0;
      memory_data_out <= '0;
      mem_fault       <= 1'b0;
    end else begin
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start_access) begin
            shadow_q      <= fields_in;
            shadow_load   <= is_load;
            wb_q.ctr_word <= 3'b000;
            cnt           <= '0;
            bus_req       <= 1'b1;
            bus_we        <= is_store;
            bus_addr      <= alu_in[31:2];
            bus_wstrb     <= is_store ? st_wstrb : 4'b1111;
            bus_wdata     <= is_store ? st_wdata : 32'h0;
          end else if (accept) begin
            wb_q <= fields_in;
            if (reject_access) begin
              wb_q.ctr_word <= 3'b000;
              mem_fault     <= 1'b1;
            end
          end else begin
            wb_q.ctr_word <= 3'b000;
          end
        end
        BUS_WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            wb_q    <= shadow_q;
            if (bus_err) begin
              wb_q.ctr_word <= 3'b000;
              mem_fault     <= 1'b1;
            end
            if (shadow_load) memory_data_out <= bus_rdata;
          end else if (timeout_hit) begin
            bus_req       <= 1'b0;
            wb_q.ctr_word <= 3'b000;
            mem_fault     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ctr_word_out   = wb_q.ctr_word;
  assign fn3_out        = wb_q.fn3;
  assign rd_addr_out    = wb_q.rd_addr;
  assign alu_out        = wb_q.alu;
  assign inc_pc_out     = wb_q.inc_pc;
  assign u_type_imm_out = wb_q.u_type_imm;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: pass-through, load/store bus
// handshakes, faults, timeout and asynchronous reset.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mem_op_in;
  logic [2:0]  ctr_word_in;
  logic [2:0]  fn3_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] alu_in;
  logic [31:0] store_data_in;
  logic [29:0] inc_pc_in;
  logic [19:0] u_type_imm_in;
  logic        bus_req, bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;
  logic [2:0]  ctr_word_out, fn3_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] alu_out;
  logic [29:0] inc_pc_out;
  logic [19:0] u_type_imm_out;
  logic [31:0] memory_data_out;
  logic        mem_fault;

  int checks = 0;
  int errors = 0;

  memory_stage #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_op_in(mem_op_in), .ctr_word_in(ctr_word_in), .fn3_in(fn3_in),
    .rd_addr_in(rd_addr_in), .alu_in(alu_in), .store_data_in(store_data_in),
    .inc_pc_in(inc_pc_in), .u_type_imm_in(u_type_imm_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_err(bus_err), .bus_rdata(bus_rdata),
    .ctr_word_out(ctr_word_out), .fn3_out(fn3_out), .rd_addr_out(rd_addr_out),
    .alu_out(alu_out), .inc_pc_out(inc_pc_out), .u_type_imm_out(u_type_imm_out),
    .memory_data_out(memory_data_out), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [2:0] cw,
                       input logic [31:0] addr, input logic [31:0] data);
    in_valid      = 1'b1;
    mem_op_in     = op;
    fn3_in        = f3;
    ctr_word_in   = cw;
    rd_addr_in    = 5'd7;
    alu_in        = addr;
    store_data_in = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; mem_op_in = 0; ctr_word_in = 0; fn3_in = 0; rd_addr_in = 0;
    alu_in = 0; store_data_in = 0; inc_pc_in = 0; u_type_imm_in = 0;
    bus_ack = 0; bus_err = 0; bus_rdata = 0;
    #23;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus_req); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    checks++; if ({ctr_word_out, alu_out, memory_data_out, mem_fault} !== '0)
      begin errors++; $display("FAIL reset_outs got %h/%h/%h/%b want 0", ctr_word_out, alu_out, memory_data_out, mem_fault); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_op();
    issue(2'b00, 3'd0, 3'b001, 32'h1234, 32'h0);
    rd_addr_in = 5'd5; inc_pc_in = 30'h123; u_type_imm_in = 20'hABCDE;
    step();
    in_valid = 1'b0;
    checks++; if (alu_out !== 32'h1234) begin errors++; $display("FAIL alu_out got %h want 00001234", alu_out); end
    checks++; if (ctr_word_out !== 3'b001) begin errors++; $display("FAIL alu_ctr got %b want 001", ctr_word_out); end
    checks++; if ({rd_addr_out, inc_pc_out, u_type_imm_out} !== {5'd5, 30'h123, 20'hABCDE})
      begin errors++; $display("FAIL alu_fields got %0d/%h/%h want 5/123/abcde", rd_addr_out, inc_pc_out, u_type_imm_out); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL alu_noreq got %b want 0", bus_req); end
    step();
    checks++; if (ctr_word_out !== 3'b000) begin errors++; $display("FAIL alu_bubble got %b want 000", ctr_word_out); end
    checks++; if (alu_out !== 32'h1234) begin errors++; $display("FAIL alu_hold got %h want 00001234", alu_out); end
  endtask

  task automatic test_lw_wait();
    issue(2'b01, 3'd2, 3'b011, 32'h100, 32'h0);
    step();
    in_valid = 1'b0;
    checks++; if ({bus_addr, bus_we, bus_wstrb, bus_wdata} !== {30'h40, 1'b0, 4'b1111, 32'h0})
      begin errors++; $display("FAIL lw_bus got %h/%b/%b/%h want 40/0/1111/0", bus_addr, bus_we, bus_wstrb, bus_wdata); end
    checks++; if (ctr_word_out !== 3'b000) begin errors++; $display("FAIL lw_ctr_wait got %b want 000", ctr_word_out); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_req !== 1'b1 || in_ready !== 1'b0 || bus_addr !== 30'h40)
        begin errors++; $display("FAIL lw_req_c%0d got req=%b rdy=%b addr=%h want 1/0/40", i, bus_req, in_ready, bus_addr); end
      if (i == 3) begin bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF; end
      step();
    end
    bus_ack = 1'b0; bus_rdata = 32'h0;
    checks++; if (bus_req !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL lw_done got req=%b rdy=%b want 0/1", bus_req, in_ready); end
    checks++; if (memory_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", memory_data_out); end
    checks++; if (ctr_word_out !== 3'b011 || alu_out !== 32'h100 || rd_addr_out !== 5'd7)
      begin errors++; $display("FAIL lw_wb got %b/%h/%0d want 011/100/7", ctr_word_out, alu_out, rd_addr_out); end
    step();
    checks++; if (ctr_word_out !== 3'b000) begin errors++; $display("FAIL lw_once got %b want 000", ctr_word_out); end
  endtask

  task automatic test_stores();
    logic [31:0] exp_wdata [2] = '{32'hABABABAB, 32'h12341234};
    logic [3:0]  exp_wstrb [2] = '{4'b1000, 4'b1100};
    logic [31:0] addr      [2] = '{32'h203, 32'h202};
    logic [31:0] data      [2] = '{32'h000000AB, 32'h00001234};
    for (int i = 0; i < 2; i++) begin
      issue(2'b10, i[2:0], 3'b000, addr[i], data[i]);
      step();
      in_valid = 1'b0;
      checks++; if ({bus_req, bus_we, bus_wstrb, bus_wdata, bus_addr} !== {2'b11, exp_wstrb[i], exp_wdata[i], 30'h80})
        begin errors++; $display("FAIL store%0d_bus got req=%b we=%b strb=%b data=%h addr=%h want 1/1/%b/%h/80",
                                 i, bus_req, bus_we, bus_wstrb, bus_wdata, bus_addr, exp_wstrb[i], exp_wdata[i]); end
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      checks++; if (bus_req !== 1'b0 || mem_fault !== 1'b0 || memory_data_out !== 32'hDEADBEEF)
        begin errors++; $display("FAIL store%0d_done got req=%b flt=%b mdata=%h want 0/0/deadbeef", i, bus_req, mem_fault, memory_data_out); end
    end
  endtask

  task automatic test_faults();
    logic [1:0]  op   [3] = '{2'b01, 2'b10, 2'b01};
    logic [2:0]  f3   [3] = '{3'd2, 3'd4, 3'd3};
    logic [31:0] addr [3] = '{32'h102, 32'h0, 32'h8};
    for (int i = 0; i < 3; i++) begin
      issue(op[i], f3[i], 3'b011, addr[i], 32'h55);
      step();
      in_valid = 1'b0;
      checks++; if ({bus_req, mem_fault, ctr_word_out, in_ready} !== {1'b0, 1'b1, 3'b000, 1'b1})
        begin errors++; $display("FAIL fault%0d got req=%b flt=%b ctr=%b rdy=%b want 0/1/000/1", i, bus_req, mem_fault, ctr_word_out, in_ready); end
      checks++; if (alu_out !== addr[i] || fn3_out !== f3[i])
        begin errors++; $display("FAIL fault%0d_fields got %h/%0d want %h/%0d", i, alu_out, fn3_out, addr[i], f3[i]); end
      step();
      checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL fault%0d_pulse got %b want 0", i, mem_fault); end
    end
  endtask

  task automatic test_timeout();
    issue(2'b01, 3'd2, 3'b011, 32'h10, 32'h0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_req !== 1'b1 || mem_fault !== 1'b0)
        begin errors++; $display("FAIL tmo_req_c%0d got req=%b flt=%b want 1/0", i, bus_req, mem_fault); end
      step();
    end
    checks++; if ({bus_req, mem_fault, ctr_word_out, in_ready} !== {1'b0, 1'b1, 3'b000, 1'b1})
      begin errors++; $display("FAIL tmo_abort got req=%b flt=%b ctr=%b rdy=%b want 0/1/000/1", bus_req, mem_fault, ctr_word_out, in_ready); end
    bus_ack = 1'b1; bus_rdata = 32'h77;
    step();
    bus_ack = 1'b0;
    checks++; if ({bus_req, mem_fault, ctr_word_out} !== 5'b0 || memory_data_out !== 32'hDEADBEEF)
      begin errors++; $display("FAIL tmo_late_ack got req=%b flt=%b ctr=%b mdata=%h want 0/0/000/deadbeef", bus_req, mem_fault, ctr_word_out, memory_data_out); end
  endtask

  task automatic test_bus_err();
    issue(2'b01, 3'd1, 3'b011, 32'h104, 32'h0);
    step();
    in_valid = 1'b0;
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h5555AAAA;
    step();
    bus_ack = 1'b0; bus_err = 1'b0;
    checks++; if ({bus_req, mem_fault, ctr_word_out} !== {1'b0, 1'b1, 3'b000})
      begin errors++; $display("FAIL err_ack got req=%b flt=%b ctr=%b want 0/1/000", bus_req, mem_fault, ctr_word_out); end
    step();
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", mem_fault); end
  endtask

  task automatic test_reset_mid();
    issue(2'b01, 3'd2, 3'b011, 32'h200, 32'h0);
    step();
    in_valid = 1'b0;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", bus_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_req got req=%b rdy=%b want 0/1", bus_req, in_ready); end
    checks++; if ({ctr_word_out, alu_out, memory_data_out, mem_fault} !== '0)
      begin errors++; $display("FAIL rstmid_outs got %b/%h/%h/%b want 0", ctr_word_out, alu_out, memory_data_out, mem_fault); end
    #3 rst_n = 1'b1;
    step();
    checks++; if (bus_req !== 1'b0 || ctr_word_out !== 3'b000)
      begin errors++; $display("FAIL rstmid_after got req=%b ctr=%b want 0/000", bus_req, ctr_word_out); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_lw_wait();
    test_stores();
    test_faults();
    test_timeout();
    test_bus_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
